// File: rtl/eth_rx_ring_if.sv
// Receive byte stream into the ring: one byte per valid beat, no backpressure.
interface eth_rx_ring_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_rx_ring.sv
// Ethernet receive ring: frames land in fixed-size slots, CPU reads 64-bit words and pops.
// state   | meaning
// IDLE    | between frames; first valid beat starts a frame or, if the ring is full, a discard
// RECV    | storing bytes of the current frame into slot tail
// DISCARD | ring was full at frame start; ignore bytes until tlast
module eth_rx_ring #(
    parameter int NBUF     = 8,
    parameter int FRAME_AW = 11,
    parameter int MIN_LEN  = 14,
    localparam int BW = $clog2(NBUF),
    localparam int LW = FRAME_AW + 1,
    localparam int AW = BW + FRAME_AW - 3
) (
    input  logic              clk_int,
    input  logic              rst_int_n,
    eth_rx_ring_if.slave      rx_axis,
    input  logic [47:0]       mac_address,
    input  logic              promiscuous,
    input  logic              irq_en,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [63:0]       rd_data,
    input  logic              pop,
    input  logic              drop_clr,
    output logic [BW-1:0]     head,
    output logic [BW:0]       count,
    output logic [LW-1:0]     head_len,
    output logic [15:0]       drop_cnt,
    output logic              eth_irq
);

    localparam int NWORDS = NBUF << (FRAME_AW - 3);
    localparam logic [LW:0] SLOT_BYTES = (LW+1)'(1 << FRAME_AW);
    localparam logic [LW:0] MIN_BYTES  = (LW+1)'(MIN_LEN);
    localparam logic [BW:0] FULL       = (BW+1)'(NBUF);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   ofs_q, ofs_d, cur_ofs;
    logic [BW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [BW:0]     count_q, count_d;
    logic [47:0]     dest_q, dest_d, dest_shift;
    logic [15:0]     drop_q, drop_d;
    logic            irq_q;
    logic [63:0]     rd_data_q;
    logic [LW-1:0]   len_q [NBUF];
    logic [63:0]     mem_q [NWORDS];

    logic            full, dest_hit, accept, pop_ok;
    logic            wr_en, frame_end, commit, drop_evt;
    logic [LW:0]     frame_len;

    assign full       = (count_q == FULL);
    assign cur_ofs    = (state_q == S_IDLE) ? '0 : ofs_q;
    assign frame_len  = {1'b0, cur_ofs} + (LW+1)'(1);
    assign dest_shift = (cur_ofs < LW'(6)) ? {dest_q[39:0], rx_axis.tdata} : dest_q;
    // dest[40] is the group bit of the first destination byte
    assign dest_hit   = (dest_shift == mac_address) || (&dest_shift) || dest_shift[40] || promiscuous;
    assign accept     = ~rx_axis.tuser && (frame_len >= MIN_BYTES) && (frame_len <= SLOT_BYTES) && dest_hit;
    assign pop_ok     = pop && (count_q != '0);

    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_axis.tvalid && !rx_axis.tlast) state_d = full ? S_DISCARD : S_RECV;
            end
            S_RECV, S_DISCARD: begin
                if (rx_axis.tvalid && rx_axis.tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        frame_end = 1'b0;
        drop_evt  = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_axis.tvalid) begin
                    if (full) begin
                        drop_evt = rx_axis.tlast;
                    end else begin
                        wr_en     = 1'b1;
                        frame_end = rx_axis.tlast;
                    end
                end
            end
            S_RECV: begin
                if (rx_axis.tvalid) begin
                    wr_en     = ~ofs_q[FRAME_AW];
                    frame_end = rx_axis.tlast;
                end
            end
            S_DISCARD: drop_evt = rx_axis.tvalid && rx_axis.tlast;
            default: ;
        endcase
        if (frame_end) begin
            commit   = accept;
            drop_evt = ~accept;
        end
    end

    always_comb begin
        ofs_d   = ofs_q;
        dest_d  = dest_q;
        tail_d  = tail_q;
        head_d  = head_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (rx_axis.tvalid) begin
            case (state_q)
                S_IDLE: begin
                    if (!full) begin
                        ofs_d  = LW'(1);
                        dest_d = dest_shift;
                    end
                end
                S_RECV: begin
                    dest_d = dest_shift;
                    if (!ofs_q[FRAME_AW]) ofs_d = ofs_q + LW'(1);
                end
                default: ;
            endcase
            if (rx_axis.tlast) ofs_d = '0;
        end
        if (commit) tail_d = tail_q + BW'(1);
        if (pop_ok) head_d = head_q + BW'(1);
        case ({commit, pop_ok})
            2'b10:   count_d = count_q + (BW+1)'(1);
            2'b01:   count_d = count_q - (BW+1)'(1);
            default: count_d = count_q;
        endcase
        if (drop_clr)                              drop_d = '0;
        else if (drop_evt && drop_q != 16'hFFFF)   drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ofs_q     <= '0;
            dest_q    <= '0;
            tail_q    <= '0;
            head_q    <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            irq_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            ofs_q   <= ofs_d;
            dest_q  <= dest_d;
            tail_q  <= tail_d;
            head_q  <= head_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            irq_q   <= irq_en && (count_q != '0);
            if (rd_en) rd_data_q <= mem_q[rd_addr];
        end
    end

    // Storage is not reset; stale contents are only visible in uncommitted slots.
    always_ff @(posedge clk_int) begin
        if (wr_en) mem_q[{tail_q, cur_ofs[FRAME_AW-1:3]}][{cur_ofs[2:0], 3'b000} +: 8] <= rx_axis.tdata;
        if (commit) len_q[tail_q] <= frame_len[LW-1:0];
    end

    assign rd_data  = rd_data_q;
    assign head     = head_q;
    assign count    = count_q;
    assign head_len = len_q[head_q];
    assign drop_cnt = drop_q;
    assign eth_irq  = irq_q;

endmodule

// File: tb/tb_eth_rx_ring.sv
// Randomized bench for eth_rx_ring against a frame-level queue/array model of the ring.
module tb_eth_rx_ring;
    localparam int NBUF = 8;
    localparam int FA   = 11;
    localparam int MINL = 14;
    localparam int BW   = 3;
    localparam int LW   = FA + 1;
    localparam int AW   = BW + FA - 3;
    localparam int SLOT = 1 << FA;

    logic clk_int = 1'b0;
    logic rst_int_n = 1'b0;
    eth_rx_ring_if rx_if();
    logic [47:0]   mac_address;
    logic          promiscuous, irq_en, rd_en, pop, drop_clr;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [BW-1:0] head;
    logic [BW:0]   count;
    logic [LW-1:0] head_len;
    logic [15:0]   drop_cnt;
    logic          eth_irq;

    always #5 clk_int = ~clk_int;

    eth_rx_ring #(.NBUF(NBUF), .FRAME_AW(FA), .MIN_LEN(MINL)) dut (
        .clk_int(clk_int), .rst_int_n(rst_int_n), .rx_axis(rx_if),
        .mac_address(mac_address), .promiscuous(promiscuous), .irq_en(irq_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pop(pop),
        .drop_clr(drop_clr), .head(head), .count(count), .head_len(head_len),
        .drop_cnt(drop_cnt), .eth_irq(eth_irq)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mmem [NBUF][SLOT];
    int          mlen [NBUF];
    logic [7:0]  fq[$];
    bit          m_in, m_disc, m_irq, rd_chk, popok, dinc, ok;
    int          m_head, m_tail, m_count, m_drop, c0, flen, sl, wd;
    logic [47:0] dq;
    logic [63:0] rd_exp;

    task automatic model_end();
        m_in = 0;
        flen = fq.size();
        dq = '0;
        if (flen >= 6) for (int i = 0; i < 6; i++) dq = {dq[39:0], fq[i]};
        ok = !rx_if.tuser && flen >= MINL && flen <= SLOT &&
             (dq == mac_address || dq == 48'hFFFF_FFFF_FFFF || dq[40] || promiscuous);
        if (ok) begin
            for (int i = 0; i < flen; i++) mmem[m_tail][i] = fq[i];
            mlen[m_tail] = flen;
            m_tail = (m_tail + 1) % NBUF;
            m_count++;
        end else begin
            dinc = 1;
        end
    endtask

    always @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            m_in = 0; m_disc = 0; m_irq = 0; rd_chk = 0;
            m_head = 0; m_tail = 0; m_count = 0; m_drop = 0;
            fq.delete();
        end else begin
            c0 = m_count;
            dinc = 0;
            m_irq = irq_en && (c0 != 0);
            rd_chk = 0;
            if (rd_en) begin
                sl = int'(rd_addr >> (FA - 3));
                wd = int'(rd_addr) & ((1 << (FA - 3)) - 1);
                if (((sl - m_head + NBUF) % NBUF) < c0 && 8 * wd + 8 <= mlen[sl]) begin
                    rd_chk = 1;
                    for (int k = 0; k < 8; k++) rd_exp[8*k +: 8] = mmem[sl][8*wd + k];
                end
            end
            popok = pop && (c0 > 0);
            if (rx_if.tvalid) begin
                if (m_disc) begin
                    if (rx_if.tlast) begin m_disc = 0; dinc = 1; end
                end else if (!m_in) begin
                    if (c0 == NBUF) begin
                        if (rx_if.tlast) dinc = 1;
                        else m_disc = 1;
                    end else begin
                        fq.delete();
                        fq.push_back(rx_if.tdata);
                        m_in = 1;
                        if (rx_if.tlast) model_end();
                    end
                end else begin
                    fq.push_back(rx_if.tdata);
                    if (rx_if.tlast) model_end();
                end
            end
            if (popok) begin
                m_head = (m_head + 1) % NBUF;
                m_count--;
            end
            if (drop_clr) m_drop = 0;
            else if (dinc && m_drop < 65535) m_drop++;
        end
    end

    always @(negedge clk_int) begin
        if (rst_int_n) begin
            chk("count", 64'(count), 64'(m_count));
            chk("head", 64'(head), 64'(m_head));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("eth_irq", 64'(eth_irq), 64'(m_irq));
            if (m_count > 0) chk("head_len", 64'(head_len), 64'(mlen[m_head]));
            if (rd_chk) chk("rd_data", rd_data, rd_exp);
        end
    end

    // ---------------- stimulus ----------------
    bit            rnd_mode = 0;
    int            pop_div = 4;
    bit            pop_req = 0, rd_req = 0, clr_req = 0;
    logic [AW-1:0] rd_req_addr = '0;

    task automatic beat(input bit v, input logic [7:0] d, input bit l, input bit u);
        @(posedge clk_int); #1;
        rx_if.tvalid = v; rx_if.tdata = d; rx_if.tlast = l; rx_if.tuser = u;
        if (rnd_mode) begin
            pop      = ($urandom % pop_div) == 0;
            rd_en    = $urandom % 2;
            rd_addr  = AW'($urandom);
            drop_clr = ($urandom % 300) == 0;
            if ($urandom % 50 == 0) irq_en = ~irq_en;
        end else begin
            pop = pop_req; rd_en = rd_req; rd_addr = rd_req_addr; drop_clr = clr_req;
            pop_req = 0; rd_req = 0; clr_req = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 8'h00, 0, 0);
    endtask

    task automatic send_frame(input logic [47:0] dst, input int len, input bit u,
                              input bit gaps, input bit pop_last);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = (i < 6) ? dst[47 - 8*i -: 8] : (gaps ? 8'($urandom) : 8'(i));
            if (gaps && $urandom % 4 == 0) beat(0, 8'h00, 0, 0);
            if (i == len - 1) pop_req = pop_last;
            beat(1, d, i == len - 1, u);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk_int); #3;
        rst_int_n = 0;
        rx_if.tvalid = 0; rx_if.tlast = 0; rx_if.tuser = 0; rx_if.tdata = 0;
        pop = 0; rd_en = 0; drop_clr = 0; rd_addr = '0;
        repeat (2) @(posedge clk_int);
        #3 rst_int_n = 1;
    endtask

    localparam logic [48:0] MAC   = 49'h0_0211_2233_4455;
    localparam logic [47:0] OTHER = 48'h02AA_BBCC_DDEE;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MCAST = 48'h0100_5E00_0001;

    initial begin
        logic [47:0] dst;
        int          len;
        mac_address = MAC[47:0];
        promiscuous = 0; irq_en = 0;
        rx_if.tvalid = 0; rx_if.tlast = 0; rx_if.tuser = 0; rx_if.tdata = 0;
        pop = 0; rd_en = 0; drop_clr = 0; rd_addr = '0;
        apply_reset();
        idle(1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_head", 64'(head), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_irq", 64'(eth_irq), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);

        // unicast 64-byte frame
        irq_en = 1;
        send_frame(MAC[47:0], 64, 0, 0, 0);
        idle(2);
        chk("uc_count", 64'(count), 64'd1);
        chk("uc_head_len", 64'(head_len), 64'd64);
        chk("uc_irq", 64'(eth_irq), 64'd1);
        rd_req = 1; rd_req_addr = '0;
        idle(2);
        chk("uc_rd_data", rd_data, 64'h0706_5544_3322_1102);
        irq_en = 0;
        idle(2);
        chk("irq_off", 64'(eth_irq), 64'd0);

        // overflow: NBUF+1 broadcast frames
        apply_reset();
        for (int f = 0; f < NBUF + 1; f++) send_frame(BCAST, 60, 0, 0, 0);
        idle(1);
        chk("full_count", 64'(count), 64'(NBUF));
        chk("full_drop", 64'(drop_cnt), 64'd1);
        pop_req = 1;
        idle(2);
        chk("pop_head", 64'(head), 64'd1);
        chk("pop_count", 64'(count), 64'(NBUF - 1));

        // rejection rules and length boundaries
        apply_reset();
        send_frame(MAC[47:0], 10, 0, 0, 0);
        send_frame(MAC[47:0], SLOT + 1, 0, 0, 0);
        send_frame(MAC[47:0], 64, 1, 0, 0);
        send_frame(OTHER, 64, 0, 0, 0);
        idle(1);
        chk("rej_drop", 64'(drop_cnt), 64'd4);
        chk("rej_count", 64'(count), 64'd0);
        promiscuous = 1;
        send_frame(OTHER, 64, 0, 0, 0);
        idle(1);
        promiscuous = 0;
        chk("prom_count", 64'(count), 64'd1);
        send_frame(MAC[47:0], MINL - 1, 0, 0, 0);
        send_frame(MAC[47:0], MINL, 0, 0, 0);
        send_frame(MAC[47:0], SLOT, 0, 0, 0);
        send_frame(MCAST, 64, 0, 0, 0);
        idle(1);
        chk("bnd_drop", 64'(drop_cnt), 64'd5);
        chk("bnd_count", 64'(count), 64'd4);

        // commit coincident with pop, then pointer wrap
        apply_reset();
        send_frame(MAC[47:0], 60, 0, 0, 0);
        send_frame(MAC[47:0], 61, 0, 0, 0);
        send_frame(MAC[47:0], 62, 0, 0, 1);
        idle(1);
        chk("cp_count", 64'(count), 64'd2);
        chk("cp_head", 64'(head), 64'd1);
        for (int f = 0; f < 2 * NBUF; f++) send_frame(MAC[47:0], 20 + f, 0, 0, 1);
        idle(1);
        chk("wrap_head", 64'(head), 64'd1);
        chk("wrap_count", 64'(count), 64'd2);
        chk("wrap_head_len", 64'(head_len), 64'd34);

        // reset in the middle of a frame
        apply_reset();
        for (int i = 0; i < 29; i++) beat(1, (i < 6) ? MAC[47 - 8*i -: 8] : 8'(i), 0, 0);
        beat(1, 8'h1D, 0, 0);
        #3 rst_int_n = 0;
        rx_if.tvalid = 0;
        repeat (2) @(posedge clk_int);
        #3 rst_int_n = 1;
        send_frame(MAC[47:0], 64, 0, 0, 0);
        idle(1);
        chk("mid_rst_count", 64'(count), 64'd1);
        chk("mid_rst_len", 64'(head_len), 64'd64);
        chk("mid_rst_drop", 64'(drop_cnt), 64'd0);

        // drop counter saturation and clear priority
        apply_reset();
        for (int i = 0; i < 65535; i++) beat(1, 8'h00, 1, 0);
        idle(1);
        chk("sat_reach", 64'(drop_cnt), 64'hFFFF);
        beat(1, 8'h00, 1, 0);
        idle(1);
        chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
        clr_req = 1;
        beat(1, 8'h00, 1, 0);
        idle(1);
        chk("clr_wins", 64'(drop_cnt), 64'd0);

        // randomized traffic
        apply_reset();
        irq_en = 1;
        rnd_mode = 1;
        for (int f = 0; f < 100; f++) begin
            pop_div = (f < 50) ? 3 : 40;
            case ($urandom % 5)
                0: dst = MAC[47:0];
                1: dst = BCAST;
                2: dst = MCAST;
                3: dst = {8'h02, 40'($urandom)};
                default: dst = MAC[47:0];
            endcase
            len = ($urandom % 50 == 0) ? int'($urandom_range(SLOT - 1, SLOT + 1))
                                       : int'($urandom_range(8, 90));
            promiscuous = ($urandom % 6) == 0;
            send_frame(dst, len, ($urandom % 8) == 0, 1, 0);
        end
        rnd_mode = 0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/eth_rx_ring.md
ETH_RX_RING -- requirements
Module: eth_rx_ring

Interface
REQ-001 Parameter NBUF, default 8, number of receive slots; power of two, 2..16.
REQ-002 Parameter FRAME_AW, default 11, log2 of slot size in bytes; slot holds 2^FRAME_AW bytes.
REQ-003 Parameter MIN_LEN, default 14, minimum accepted frame length in bytes.
REQ-004 Derived widths: BW = log2(NBUF); LW = FRAME_AW+1.
REQ-005 clk_int  in  1  sole clock; all logic on rising edge.
REQ-006 rst_int_n  in  1  asynchronous, active-low reset.
REQ-007 rx_axis_tdata  in  8  received byte.
REQ-008 rx_axis_tvalid  in  1  byte valid; no backpressure exists, the block accepts every valid beat.
REQ-009 rx_axis_tlast  in  1  last byte of frame.
REQ-010 rx_axis_tuser  in  1  frame error, sampled with tlast.
REQ-011 mac_address  in  48  station address; byte 0 on the wire is bits 47:40.
REQ-012 promiscuous  in  1  accept any destination address.
REQ-013 irq_en  in  1  interrupt enable.
REQ-014 rd_en  in  1  CPU read strobe.
REQ-015 rd_addr  in  BW+FRAME_AW-3  64-bit word address: upper BW bits = slot, lower = word in slot.
REQ-016 rd_data  out  64  read data; byte at slot offset 8w+k in bits 8k+7:8k.
REQ-017 pop  in  1  release the oldest filled slot.
REQ-018 drop_clr  in  1  clear drop counter.
REQ-019 head  out  BW  index of oldest filled slot.
REQ-020 count  out  BW+1  number of filled slots.
REQ-021 head_len  out  LW  byte length of slot head (valid while count>0).
REQ-022 drop_cnt  out  16  dropped-frame counter.
REQ-023 eth_irq  out  1  interrupt, registered.

Function
REQ-024 Receive FSM states IDLE, RECV, DISCARD; byte offset counter ofs (LW bits) and tail pointer (BW bits).
REQ-025 IDLE + tvalid: if count==NBUF -> DISCARD (count before any same-cycle pop); else write byte to slot tail offset 0, ofs<=1, -> RECV.
REQ-026 RECV + tvalid: byte written to tail at ofs only while ofs<2^FRAME_AW; ofs increments, saturating at 2^FRAME_AW.
REQ-027 First 6 bytes of each frame are shifted into dest register, first byte ending in bits 47:40.
REQ-028 On tlast beat (including single-beat frame from IDLE), length L = bytes in frame including that beat; frame accepted iff tuser==0, MIN_LEN<=L<=2^FRAME_AW, and (dest==mac_address or dest==all-ones or dest[40]==1 or promiscuous).
REQ-029 Accept: len[tail]<=L, tail<=tail+1 (mod NBUF), count+1 on the following cycle; FSM -> IDLE.
REQ-030 Reject: slot not committed, tail unchanged, drop_cnt+1; FSM -> IDLE.
REQ-031 DISCARD: bytes ignored; on tlast drop_cnt+1, -> IDLE.
REQ-032 pop with count>0: head<=head+1 (mod NBUF), count-1; pop with count==0 ignored.
REQ-033 Commit and pop same cycle: count unchanged, both pointers advance.
REQ-034 drop_cnt saturates at 0xFFFF; drop_clr sets 0 and overrides a same-cycle increment.
REQ-035 Buffer RAM NBUF*2^FRAME_AW bytes, byte write port, 64-bit read port; rd_data valid exactly one cycle after rd_en, holds otherwise; reads of an uncommitted slot return unspecified data.
REQ-036 eth_irq <= irq_en & (count!=0) each cycle; deasserts one cycle after irq_en falls.
REQ-037 head_len combinational from len[head].

Reset
REQ-038 rst_int_n low: FSM IDLE, head=tail=0, count=0, ofs=0, dest=0, drop_cnt=0, eth_irq=0, rd_data=0; len array and RAM not reset.
REQ-039 Reset mid-frame discards the partial frame; first valid beat after release starts a new frame.

Verification
REQ-040 Unicast 64-byte frame, dest=mac_address, tuser=0 -> count=1, head_len=64, eth_irq=1 with irq_en, rd_addr 0 rd_data = first 8 bytes little-endian.
REQ-041 NBUF+1 broadcast 60-byte frames, no pop -> count=NBUF, drop_cnt=1; one pop -> head=1, count=NBUF-1.
REQ-042 Frames: 10 bytes; 2^FRAME_AW+1 bytes; tuser=1; dest mismatch with promiscuous=0 -> all dropped, drop_cnt=4, count=0; repeat mismatch with promiscuous=1 -> accepted.
REQ-043 Commit on same cycle as pop with count=2 -> count stays 2, head and tail both advance; 2*NBUF frames with pops -> pointers wrap correctly.
REQ-044 rst_int_n low during byte 30 of a frame, release, send 64-byte frame -> count=1, head_len=64, drop_cnt=0.
REQ-045 drop_cnt at 0xFFFF plus drop -> stays 0xFFFF; drop_clr with simultaneous drop -> 0.
